ccm_bank_ctrl: RTL and testbench
================================

# ccm_bank_ctrl

Second-generation closely-coupled-memory bank controller between the core's load/store port and one two-port synchronous SRAM (one read port, one write port). It adds byte-enable writes, a configurable memory depth with out-of-range detection, and a read-after-write forwarding path. The forwarding path covers the hazard created by the registered write path. An optional output register on read data allows timing closure at higher clock rates.

## Interface
- `ADDR_WIDTH`, 11: word-address width.
- `DATA_WIDTH`, 32: word width; must be a multiple of 8.
- `DEPTH`, 2048: implemented words; must satisfy DEPTH <= 2**ADDR_WIDTH.
- `RD_PIPE`, 0: 0 = read data at issue+1; 1 = extra output register, data at issue+2.
- `BE_WIDTH`, DATA_WIDTH/8: derived; not overridden.

- `clk` in 1: clock.
- `rst_n` in 1: reset, asynchronous, active-low.
- `cntlr_rd` in 1: read request, one word per cycle.
- `cntlr_raddr` in ADDR_WIDTH: read word address.
- `cntlr_rd_data` out DATA_WIDTH: read data.
- `cntlr_rd_valid` out 1: read data valid, one pulse per accepted read.
- `cntlr_rd_err` out 1: pulses with `cntlr_rd_valid` when the read address is >= DEPTH.
- `cntlr_wr` in 1: write request.
- `cntlr_waddr` in ADDR_WIDTH: write word address.
- `cntlr_wr_data` in DATA_WIDTH: write data.
- `cntlr_wr_be` in BE_WIDTH: byte enables.
- `cntlr_wr_err` out 1: pulses one cycle after a write with address >= DEPTH.
- `mem_rd` out 1: SRAM read enable.
- `mem_rd_addr` out ADDR_WIDTH: SRAM read address.
- `mem_rd_data` in DATA_WIDTH: SRAM read data, valid the cycle after `mem_rd`.
- `mem_wr` out 1: SRAM write enable.
- `mem_wr_addr` out ADDR_WIDTH: SRAM write address.
- `mem_wr_data` out DATA_WIDTH: SRAM write data.
- `mem_wr_be` out BE_WIDTH: SRAM byte write mask.

## Operation
- **Write path**
  - Registered, one stage.
  - A write in cycle t with addr < DEPTH drives `mem_wr`=1 with addr, data and be in t+1. The SRAM commits at the end of t+1.
  - A write with addr >= DEPTH gives `mem_wr`=0 and `cntlr_wr_err`=1 in t+1.
  - A write with be=0 is legal. It passes to the SRAM with mask 0, and the SRAM does not change.
- **Read path**
  - `mem_rd` = `cntlr_rd` && (`cntlr_raddr` < DEPTH), combinational.
  - `mem_rd_addr` = `cntlr_raddr`, combinational.
  - An out-of-range read still produces `cntlr_rd_valid`, with data 0 and `cntlr_rd_err`=1.
- **Forwarding**
  - The SRAM returns old data on a same-cycle read/write collision.
  - At a read in cycle t: if `mem_wr`=1 and `mem_wr_addr`==`cntlr_raddr`, capture `mem_wr_data` and `mem_wr_be` into fwd registers. Otherwise clear fwd_be.
  - At return, byte i = fwd_be[i] ? fwd_data byte i : `mem_rd_data` byte i.
- **Same-cycle ordering**
  - A `cntlr_rd` and `cntlr_wr` to the same address in the same cycle are ordered read-before-write. The read returns the old contents, with no forwarding.
- **Back-to-back traffic:** reads and writes may each be issued every cycle, with no stalls.
- **RD_PIPE=0**
  - `cntlr_rd_data` is the combinational merge, valid only while `cntlr_rd_valid`=1.
- **RD_PIPE=1**
  - `cntlr_rd_data` is registered. It is loaded only on valid and held between reads.

## Timing
- **Reset values:** all outputs 0; all fwd and pipeline registers 0.
- **Reset mid-operation:**
  - Reads in flight are discarded; no valid is produced after rst_n deasserts.
  - A pending write is dropped.
- **Read latency:** issue t → `cntlr_rd_valid` at t+1 (RD_PIPE=0) or t+2 (RD_PIPE=1). `cntlr_rd_err` is aligned with valid.
- **Write latency:** issue t → SRAM commit at the end of t+1. A read issued at t+2 or later gets the data from the SRAM.
- **Forward window:** exactly one cycle, covering a read issued at t+1 after a write issued at t.
- **Address compare:** full ADDR_WIDTH equality. The range check is an unsigned compare against DEPTH; it is constant-folded when DEPTH == 2**ADDR_WIDTH.

## Structure
- **Package `ccm_pkg`:** default widths, DEPTH, BE_WIDTH derivation function, and an elaboration-time check function (DATA_WIDTH%8==0, DEPTH<=2**ADDR_WIDTH).
- **Sub-module `ccm_byte_merge`:** purely combinational, parameterised on BE_WIDTH. Inputs are old word, new word and mask; output is the merged word.
- **Top-level registers:** write stage, fwd capture, valid/err pipeline, and the optional output register.

## Test plan
- Write 0xDEADBEEF, be=0xF to addr 5 at t; read addr 5 at t+3 → data 0xDEADBEEF at t+4, err=0.
- Addr 7 holds 0x11223344; write 0xAABBCCDD, be=0x5 at t; read 7 at t+1 → 0x11BB33DD at t+2 (forwarded).
- Same-cycle read and write to addr 9 (old 0x0, new 0x55) → read returns 0x0; read at t+2 → 0x55.
- DEPTH=1024: write addr 1500 → `mem_wr`=0, `wr_err` pulse; read 1500 → valid, data 0, `rd_err`=1, `mem_rd`=0.
- RD_PIPE=1: reads on 3 consecutive cycles to addrs 1,2,3 → 3 consecutive valids from t+2, data held after the last valid.
- Assert rst_n low the cycle after a read issue → no valid after release; all outputs 0 during reset.

Source files
------------

// File: rtl/ccm_bank_ctrl_pkg.sv
// Shared defaults and elaboration helpers for the CCM bank controller.
package ccm_pkg;

  localparam int unsigned CCM_ADDR_WIDTH = 11;
  localparam int unsigned CCM_DATA_WIDTH = 32;
  localparam int unsigned CCM_DEPTH      = 2048;
  localparam int unsigned CCM_RD_PIPE    = 0;

  // Read-return stage selection, named for readability at the top level.
  typedef enum int unsigned {
    CCM_RD_COMB = 0,
    CCM_RD_REG  = 1
  } ccm_rd_mode_e;

  function automatic int unsigned ccm_be_width(input int unsigned data_width);
    return data_width / 8;
  endfunction

  function automatic bit ccm_cfg_ok(input int unsigned addr_width,
                                    input int unsigned data_width,
                                    input int unsigned depth);
    return (data_width != 0) && ((data_width % 8) == 0) && (depth != 0) &&
           (64'(depth) <= (64'd1 << addr_width));
  endfunction

endpackage

// File: rtl/ccm_bank_ctrl_if.sv
// Core-side load/store port of the CCM bank controller.
interface ccm_bank_ctrl_if
  import ccm_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = CCM_ADDR_WIDTH,
  parameter int unsigned DATA_WIDTH = CCM_DATA_WIDTH
);

  localparam int unsigned BE_WIDTH = ccm_be_width(DATA_WIDTH);

  logic                  cntlr_rd;
  logic [ADDR_WIDTH-1:0] cntlr_raddr;
  logic [DATA_WIDTH-1:0] cntlr_rd_data;
  logic                  cntlr_rd_valid;
  logic                  cntlr_rd_err;
  logic                  cntlr_wr;
  logic [ADDR_WIDTH-1:0] cntlr_waddr;
  logic [DATA_WIDTH-1:0] cntlr_wr_data;
  logic [BE_WIDTH-1:0]   cntlr_wr_be;
  logic                  cntlr_wr_err;

  modport master (
    output cntlr_rd, cntlr_raddr, cntlr_wr, cntlr_waddr, cntlr_wr_data, cntlr_wr_be,
    input  cntlr_rd_data, cntlr_rd_valid, cntlr_rd_err, cntlr_wr_err
  );

  modport slave (
    input  cntlr_rd, cntlr_raddr, cntlr_wr, cntlr_waddr, cntlr_wr_data, cntlr_wr_be,
    output cntlr_rd_data, cntlr_rd_valid, cntlr_rd_err, cntlr_wr_err
  );

endinterface

// File: rtl/ccm_bank_ctrl_byte_merge.sv
// Byte-lane merge: each lane takes the new word where its mask bit is set.
module ccm_byte_merge #(
  parameter  int unsigned BE_WIDTH = 4,
  localparam int unsigned DW       = BE_WIDTH * 8
) (
  input  logic [DW-1:0]       old_word,
  input  logic [DW-1:0]       new_word,
  input  logic [BE_WIDTH-1:0] mask,
  output logic [DW-1:0]       merged
);

  for (genvar i = 0; i < BE_WIDTH; i++) begin : g_lane
    assign merged[8*i +: 8] = mask[i] ? new_word[8*i +: 8] : old_word[8*i +: 8];
  end

endmodule

// File: rtl/ccm_bank_ctrl.sv
// CCM bank controller: registered byte-enable write stage, range-checked reads and
// one-cycle read-after-write forwarding in front of a two-port synchronous SRAM.
module ccm_bank_ctrl
  import ccm_pkg::*;
#(
  parameter  int unsigned ADDR_WIDTH = CCM_ADDR_WIDTH,
  parameter  int unsigned DATA_WIDTH = CCM_DATA_WIDTH,
  parameter  int unsigned DEPTH      = CCM_DEPTH,
  parameter  int unsigned RD_PIPE    = CCM_RD_PIPE,
  localparam int unsigned BE_WIDTH   = ccm_be_width(DATA_WIDTH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  ccm_bank_ctrl_if.slave        cntlr,
  output logic                  mem_rd,
  output logic [ADDR_WIDTH-1:0] mem_rd_addr,
  input  logic [DATA_WIDTH-1:0] mem_rd_data,
  output logic                  mem_wr,
  output logic [ADDR_WIDTH-1:0] mem_wr_addr,
  output logic [DATA_WIDTH-1:0] mem_wr_data,
  output logic [BE_WIDTH-1:0]   mem_wr_be
);

  if (!ccm_cfg_ok(ADDR_WIDTH, DATA_WIDTH, DEPTH)) begin : g_cfg_err
    $error("ccm_bank_ctrl: DATA_WIDTH must be a multiple of 8 and DEPTH <= 2**ADDR_WIDTH");
  end

  // A fully mapped address space makes every address legal; the compare folds away.
  localparam bit                  FULL_MAP  = (64'(DEPTH) == (64'd1 << ADDR_WIDTH));
  localparam logic [ADDR_WIDTH:0] DEPTH_LIM = (ADDR_WIDTH+1)'(DEPTH);

  logic rd_in_range;
  logic wr_in_range;
  logic fwd_hit;

  logic                  wr_vld_q,  wr_vld_d;
  logic                  wr_err_q,  wr_err_d;
  logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
  logic [DATA_WIDTH-1:0] wr_data_q, wr_data_d;
  logic [BE_WIDTH-1:0]   wr_be_q,   wr_be_d;

  logic [DATA_WIDTH-1:0] fwd_data_q, fwd_data_d;
  logic [BE_WIDTH-1:0]   fwd_be_q,   fwd_be_d;

  logic                  rd_vld_q, rd_vld_d;
  logic                  rd_err_q, rd_err_d;

  logic [DATA_WIDTH-1:0] merged;
  logic [DATA_WIDTH-1:0] rd_word;

  assign rd_in_range = FULL_MAP || ({1'b0, cntlr.cntlr_raddr} < DEPTH_LIM);
  assign wr_in_range = FULL_MAP || ({1'b0, cntlr.cntlr_waddr} < DEPTH_LIM);

  // The write stage only ever holds in-range writes, so a hit implies an in-range read.
  // A same-cycle cntlr write is not yet on the stage, which gives read-before-write.
  assign fwd_hit = cntlr.cntlr_rd && wr_vld_q && (wr_addr_q == cntlr.cntlr_raddr);

  always_comb begin
    wr_vld_d  = cntlr.cntlr_wr && wr_in_range;
    wr_err_d  = cntlr.cntlr_wr && !wr_in_range;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    wr_be_d   = wr_be_q;
    if (wr_vld_d) begin
      wr_addr_d = cntlr.cntlr_waddr;
      wr_data_d = cntlr.cntlr_wr_data;
      wr_be_d   = cntlr.cntlr_wr_be;
    end
  end

  always_comb begin
    fwd_data_d = fwd_data_q;
    fwd_be_d   = fwd_be_q;
    if (cntlr.cntlr_rd) begin
      if (fwd_hit) begin
        fwd_data_d = wr_data_q;
        fwd_be_d   = wr_be_q;
      end else begin
        fwd_be_d   = '0;
      end
    end
  end

  always_comb begin
    rd_vld_d = cntlr.cntlr_rd;
    rd_err_d = cntlr.cntlr_rd && !rd_in_range;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_vld_q   <= 1'b0;
      wr_err_q   <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
      wr_be_q    <= '0;
      fwd_data_q <= '0;
      fwd_be_q   <= '0;
      rd_vld_q   <= 1'b0;
      rd_err_q   <= 1'b0;
    end else begin
      wr_vld_q   <= wr_vld_d;
      wr_err_q   <= wr_err_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
      wr_be_q    <= wr_be_d;
      fwd_data_q <= fwd_data_d;
      fwd_be_q   <= fwd_be_d;
      rd_vld_q   <= rd_vld_d;
      rd_err_q   <= rd_err_d;
    end
  end

  ccm_byte_merge #(
    .BE_WIDTH (BE_WIDTH)
  ) u_merge (
    .old_word (mem_rd_data),
    .new_word (fwd_data_q),
    .mask     (fwd_be_q),
    .merged   (merged)
  );

  assign rd_word = rd_err_q ? '0 : merged;

  if (RD_PIPE != CCM_RD_COMB) begin : g_rd_reg
    logic                  out_vld_q,  out_vld_d;
    logic                  out_err_q,  out_err_d;
    logic [DATA_WIDTH-1:0] out_data_q, out_data_d;

    // Data is loaded only on a returning read and held in between.
    always_comb begin
      out_vld_d  = rd_vld_q;
      out_err_d  = rd_err_q;
      out_data_d = out_data_q;
      if (rd_vld_q) begin
        out_data_d = rd_word;
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        out_vld_q  <= 1'b0;
        out_err_q  <= 1'b0;
        out_data_q <= '0;
      end else begin
        out_vld_q  <= out_vld_d;
        out_err_q  <= out_err_d;
        out_data_q <= out_data_d;
      end
    end

    assign cntlr.cntlr_rd_valid = out_vld_q;
    assign cntlr.cntlr_rd_err   = out_err_q;
    assign cntlr.cntlr_rd_data  = out_data_q;
  end else begin : g_rd_comb
    assign cntlr.cntlr_rd_valid = rd_vld_q;
    assign cntlr.cntlr_rd_err   = rd_err_q;
    assign cntlr.cntlr_rd_data  = rd_vld_q ? rd_word : '0;
  end

  assign cntlr.cntlr_wr_err = wr_err_q;

  assign mem_rd      = cntlr.cntlr_rd && rd_in_range;
  assign mem_rd_addr = cntlr.cntlr_raddr;
  assign mem_wr      = wr_vld_q;
  assign mem_wr_addr = wr_addr_q;
  assign mem_wr_data = wr_data_q;
  assign mem_wr_be   = wr_be_q;

endmodule

// File: tb/tb_ccm_bank_ctrl.sv
// Bench for ccm_bank_ctrl: a DEPTH=1024 comb-return instance and a DEPTH=2048
// registered-return instance share stimulus; a reference memory feeds per-instance queues.
module tb_ccm_bank_ctrl;
  import ccm_pkg::*;

  localparam int AW = 11;
  localparam int DW = 32;
  localparam int BW = 4;
  localparam int D0 = 1024;
  localparam int D1 = 2048;

  typedef struct {
    logic [DW-1:0] data;
    logic          err;
    int            cyc;
  } exp_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  int   cyc   = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  logic          rd    = 1'b0;
  logic [AW-1:0] raddr = '0;
  logic          wr    = 1'b0;
  logic [AW-1:0] waddr = '0;
  logic [DW-1:0] wdata = '0;
  logic [BW-1:0] be    = '0;

  ccm_bank_ctrl_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) if0 ();
  ccm_bank_ctrl_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) if1 ();

  assign if0.cntlr_rd      = rd;
  assign if0.cntlr_raddr   = raddr;
  assign if0.cntlr_wr      = wr;
  assign if0.cntlr_waddr   = waddr;
  assign if0.cntlr_wr_data = wdata;
  assign if0.cntlr_wr_be   = be;
  assign if1.cntlr_rd      = rd;
  assign if1.cntlr_raddr   = raddr;
  assign if1.cntlr_wr      = wr;
  assign if1.cntlr_waddr   = waddr;
  assign if1.cntlr_wr_data = wdata;
  assign if1.cntlr_wr_be   = be;

  logic          mrd0, mwr0, mrd1, mwr1;
  logic [AW-1:0] mra0, mwa0, mra1, mwa1;
  logic [DW-1:0] mwd0, mwd1;
  logic [DW-1:0] mrdat0 = '0;
  logic [DW-1:0] mrdat1 = '0;
  logic [BW-1:0] mbe0, mbe1;

  ccm_bank_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(D0), .RD_PIPE(0)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .cntlr(if0),
    .mem_rd(mrd0), .mem_rd_addr(mra0), .mem_rd_data(mrdat0),
    .mem_wr(mwr0), .mem_wr_addr(mwa0), .mem_wr_data(mwd0), .mem_wr_be(mbe0)
  );

  ccm_bank_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(D1), .RD_PIPE(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .cntlr(if1),
    .mem_rd(mrd1), .mem_rd_addr(mra1), .mem_rd_data(mrdat1),
    .mem_wr(mwr1), .mem_wr_addr(mwa1), .mem_wr_data(mwd1), .mem_wr_be(mbe1)
  );

  // Two-port SRAM models: old data on a same-edge read/write collision.
  logic [DW-1:0] sram0 [D1] = '{default: '0};
  logic [DW-1:0] sram1 [D1] = '{default: '0};

  always @(posedge clk) begin
    if (mrd0) mrdat0 <= sram0[mra0];
    if (mwr0) for (int b = 0; b < BW; b++) if (mbe0[b]) sram0[mwa0][8*b +: 8] <= mwd0[8*b +: 8];
  end

  always @(posedge clk) begin
    if (mrd1) mrdat1 <= sram1[mra1];
    if (mwr1) for (int b = 0; b < BW; b++) if (mbe1[b]) sram1[mwa1][8*b +: 8] <= mwd1[8*b +: 8];
  end

  logic [DW-1:0] ref0 [D1] = '{default: '0};
  logic [DW-1:0] ref1 [D1] = '{default: '0};
  exp_t          q0 [$];
  exp_t          q1 [$];
  logic [DW-1:0] last1 = '0;

  bit            cur_rd, cur_wr;
  int            cur_ra, cur_wa;
  logic [DW-1:0] cur_wd;
  logic [BW-1:0] cur_be;
  bit            pw_vld0, pw_err0, pw_vld1;
  int            pw_wa;
  logic [DW-1:0] pw_wd;
  logic [BW-1:0] pw_be;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h (cyc %0d)", tag, act, exp, cyc);
    end
  endtask

  function automatic logic [DW-1:0] apply_be(input logic [DW-1:0] old_w,
                                             input logic [DW-1:0] new_w,
                                             input logic [BW-1:0] m);
    logic [DW-1:0] r;
    r = old_w;
    for (int i = 0; i < BW; i++) if (m[i]) r[8*i +: 8] = new_w[8*i +: 8];
    return r;
  endfunction

  function automatic int rand_addr();
    case ($urandom_range(0, 2))
      0:       return int'($urandom_range(0, 15));
      1:       return 1016 + int'($urandom_range(0, 15));
      default: return 2040 + int'($urandom_range(0, 7));
    endcase
  endfunction

  task automatic monitor();
    exp_t e;
    while (q0.size() > 0 && q0[0].cyc < cyc) begin
      chk("rd0_missing", 64'd0, 64'd1);
      e = q0.pop_front();
    end
    if (if0.cntlr_rd_valid) begin
      if (q0.size() == 0) chk("rd0_unexpected", 64'd1, 64'd0);
      else begin
        e = q0.pop_front();
        chk("rd0_cyc",  64'(cyc),               64'(e.cyc));
        chk("rd0_data", 64'(if0.cntlr_rd_data), 64'(e.data));
        chk("rd0_err",  64'(if0.cntlr_rd_err),  64'(e.err));
      end
    end else chk("rd0_err_idle", 64'(if0.cntlr_rd_err), 64'd0);

    while (q1.size() > 0 && q1[0].cyc < cyc) begin
      chk("rd1_missing", 64'd0, 64'd1);
      e = q1.pop_front();
    end
    if (if1.cntlr_rd_valid) begin
      if (q1.size() == 0) chk("rd1_unexpected", 64'd1, 64'd0);
      else begin
        e = q1.pop_front();
        chk("rd1_cyc",  64'(cyc),               64'(e.cyc));
        chk("rd1_data", 64'(if1.cntlr_rd_data), 64'(e.data));
        chk("rd1_err",  64'(if1.cntlr_rd_err),  64'(e.err));
        last1 = e.data;
      end
    end else chk("rd1_hold", 64'(if1.cntlr_rd_data), 64'(last1));

    chk("mem_rd0",      64'(mrd0), 64'(cur_rd && cur_ra < D0));
    chk("mem_rd1",      64'(mrd1), 64'(cur_rd));
    chk("mem_rd_addr0", 64'(mra0), 64'(cur_ra));
    chk("mem_wr0",      64'(mwr0), 64'(pw_vld0));
    chk("wr_err0",      64'(if0.cntlr_wr_err), 64'(pw_err0));
    chk("mem_wr1",      64'(mwr1), 64'(pw_vld1));
    chk("wr_err1",      64'(if1.cntlr_wr_err), 64'd0);
    if (pw_vld0) chk("wr_bus0", 64'({mwa0, mwd0, mbe0}), 64'({AW'(pw_wa), pw_wd, pw_be}));
    if (pw_vld1) chk("wr_bus1", 64'({mwa1, mwd1, mbe1}), 64'({AW'(pw_wa), pw_wd, pw_be}));
  endtask

  task automatic latch_prev();
    pw_vld0 = cur_wr && (cur_wa < D0);
    pw_err0 = cur_wr && (cur_wa >= D0);
    pw_vld1 = cur_wr;
    pw_wa   = cur_wa;
    pw_wd   = cur_wd;
    pw_be   = cur_be;
  endtask

  task automatic step(input bit rd_i, input int ra, input bit wr_i, input int wa,
                      input logic [DW-1:0] wd, input logic [BW-1:0] b);
    @(posedge clk);
    #1;
    rd = rd_i;  raddr = AW'(ra);
    wr = wr_i;  waddr = AW'(wa);  wdata = wd;  be = b;
    cur_rd = rd_i; cur_ra = ra; cur_wr = wr_i; cur_wa = wa; cur_wd = wd; cur_be = b;
    // Reads see every write issued in earlier cycles but not this cycle's write.
    if (rd_i) begin
      if (ra < D0) q0.push_back('{data: ref0[ra], err: 1'b0, cyc: cyc + 1});
      else         q0.push_back('{data: '0,       err: 1'b1, cyc: cyc + 1});
      q1.push_back('{data: ref1[ra], err: 1'b0, cyc: cyc + 2});
    end
    if (wr_i) begin
      if (wa < D0) ref0[wa] = apply_be(ref0[wa], wd, b);
      ref1[wa] = apply_be(ref1[wa], wd, b);
    end
    @(negedge clk);
    monitor();
    latch_prev();
  endtask

  task automatic idle();
    step(1'b0, 0, 1'b0, 0, '0, '0);
  endtask

  task automatic reset_cycles(input int n);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    rd = 1'b0; raddr = '0; wr = 1'b0; waddr = '0; wdata = '0; be = '0;
    cur_rd = 1'b0; cur_ra = 0; cur_wr = 1'b0; cur_wa = 0; cur_wd = '0; cur_be = '0;
    repeat (n) begin
      @(negedge clk);
      chk("rst0_ctl",  64'({if0.cntlr_rd_valid, if0.cntlr_rd_err, if0.cntlr_wr_err, mrd0, mwr0}), 64'd0);
      chk("rst0_data", 64'(if0.cntlr_rd_data), 64'd0);
      chk("rst0_wbus", 64'({mwa0, mwd0, mbe0}), 64'd0);
      chk("rst1_ctl",  64'({if1.cntlr_rd_valid, if1.cntlr_rd_err, if1.cntlr_wr_err, mrd1, mwr1}), 64'd0);
      chk("rst1_data", 64'(if1.cntlr_rd_data), 64'd0);
      chk("rst1_wbus", 64'({mwa1, mwd1, mbe1}), 64'd0);
    end
    q0.delete();
    q1.delete();
    last1 = '0;
    latch_prev();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    monitor();
    latch_prev();
  endtask

  logic [DW-1:0] old0, old1;

  initial begin
    reset_cycles(3);
    repeat (2) idle();

    // plain write then read well after commit
    step(1'b0, 0, 1'b1, 5, 32'hDEADBEEF, 4'hF);
    idle(); idle();
    step(1'b1, 5, 1'b0, 0, '0, '0);
    idle(); idle();

    // partial write forwarded to the next-cycle read
    step(1'b0, 0, 1'b1, 7, 32'h11223344, 4'hF);
    idle(); idle();
    step(1'b0, 0, 1'b1, 7, 32'hAABBCCDD, 4'h5);
    step(1'b1, 7, 1'b0, 0, '0, '0);
    idle(); idle();

    // same-cycle read/write is read-before-write; then forwarded, then from SRAM
    step(1'b1, 9, 1'b1, 9, 32'h00000055, 4'hF);
    step(1'b1, 9, 1'b0, 0, '0, '0);
    step(1'b1, 9, 1'b0, 0, '0, '0);
    idle();

    // zero byte-enable write leaves contents untouched
    step(1'b0, 0, 1'b1, 5, 32'h12345678, 4'h0);
    step(1'b1, 5, 1'b0, 0, '0, '0);
    step(1'b1, 5, 1'b0, 0, '0, '0);
    idle();

    // range boundaries around DEPTH=1024 and the top of the 2048 map
    step(1'b0, 0, 1'b1, 1500, 32'hCAFEF00D, 4'hF);
    step(1'b1, 1500, 1'b0, 0, '0, '0);
    step(1'b1, 1023, 1'b1, 1024, 32'h0BADF00D, 4'hF);
    step(1'b1, 1024, 1'b1, 1023, 32'hA5A50001, 4'hF);
    step(1'b1, 1023, 1'b0, 0, '0, '0);
    step(1'b1, 2047, 1'b0, 0, '0, '0);
    idle(); idle();

    // back-to-back writes and reads with continuous forwarding, then hold
    step(1'b0, 0, 1'b1, 1, 32'h00000101, 4'hF);
    step(1'b1, 1, 1'b1, 2, 32'h00000202, 4'hF);
    step(1'b1, 2, 1'b1, 3, 32'h00000303, 4'hF);
    step(1'b1, 3, 1'b0, 0, '0, '0);
    repeat (4) idle();

    repeat (300) begin
      step(1'($urandom_range(0, 1)), rand_addr(), 1'($urandom_range(0, 1)), rand_addr(),
           $urandom(), 4'($urandom_range(0, 15)));
    end
    repeat (3) idle();

    // reset the cycle after a read issue; the write issued alongside it is dropped
    old0 = ref0[12];
    old1 = ref1[12];
    step(1'b1, 3, 1'b1, 12, 32'h5A5A5A5A, 4'hF);
    reset_cycles(2);
    ref0[12] = old0;
    ref1[12] = old1;
    repeat (4) idle();
    step(1'b1, 12, 1'b0, 0, '0, '0);
    repeat (4) idle();

    chk("q0_drain", 64'(q0.size()), 64'd0);
    chk("q1_drain", 64'(q1.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
